// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//
// Instruction fetch stage sitting directly in front of the decoder. It walks
// a sequential PC, issues one word fetch at a time over a single-outstanding
// valid/ready memory handshake, and queues {pc, instr, fault} entries in a
// small FIFO. The FIFO head is presented to the decoder with a valid/ready
// handshake. A redirect (flush) from execute discards everything queued and
// in flight, then restarts fetching at the new target.
//
// Parameters
//   DEPTH      FIFO entries (power of two, >= 2)
//   RESET_PC   first fetch address after reset (word aligned)
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   flush       in   redirect request from execute
//   flush_pc    in   redirect target, low two bits ignored
//   imem_valid  out  fetch request active
//   imem_addr   out  fetch address, stable while imem_valid is high
//   imem_ready  in   response valid this cycle, completes the request
//   imem_rdata  in   fetched instruction word
//   imem_error  in   access fault, qualified by imem_ready
//   out_valid   out  head entry valid toward the decoder
//   out_instr   out  head instruction (nop when out_valid is low)
//   out_pc      out  head PC (zero when out_valid is low)
//   out_fault   out  head entry carries a fetch fault
//   out_ready   in   decoder accepts the head entry
// ---------------------------------------------------------------------------
module fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        imem_error,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault,
    input  logic        out_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [31:0]      NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_FETCH,   // normal sequential fetching
        ST_DRAIN,   // waiting out a request that was in flight at a redirect
        ST_HALT     // a fault was fetched; idle until redirected
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_drain_addr;
    logic               r_req_pending;   // request raised in an earlier cycle, not yet answered

    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [31:0]        r_pc_q    [DEPTH];
    logic [31:0]        r_instr_q [DEPTH];
    logic               r_fault_q [DEPTH];

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    logic               w_imem_valid;
    logic [31:0]        w_imem_addr;
    logic               w_resp;
    logic               w_push;
    logic               w_pop;
    logic               w_out_valid;
    logic               w_hold_req;
    logic [31:0]        w_flush_target;

    // The FIFO-space check only gates the start of a request; once raised
    // the request is held by r_req_pending even if the FIFO fills meanwhile.
    // Reset gates the request combinationally so the memory sees it drop
    // the moment reset asserts.
    assign w_imem_valid = !reset &&
                          ((r_state == ST_DRAIN) ||
                           ((r_state == ST_FETCH) && (r_req_pending || (r_count != FULL_COUNT))));

    // While draining, fetch_pc already holds the redirect target, so the
    // abandoned request's address is replayed from r_drain_addr.
    assign w_imem_addr  = (r_state == ST_DRAIN) ? r_drain_addr : r_fetch_pc;

    assign imem_valid   = w_imem_valid;
    assign imem_addr    = w_imem_addr;

    assign w_resp         = w_imem_valid && imem_ready;
    assign w_hold_req     = w_imem_valid && !imem_ready;
    assign w_flush_target = flush_pc & 32'hFFFF_FFFC;

    // Flush wins over both queue operations; a response in DRAIN is dropped.
    assign w_push = w_resp && (r_state == ST_FETCH) && !flush;
    assign w_pop  = w_out_valid && out_ready && !flush;

    // ------------------------------------------------------------------
    // Fetch control FSM
    // ------------------------------------------------------------------
    // NOTE: every register below is assigned with <= so all of them sample
    // the same pre-edge values; a blocking = here would leak updated values
    // into later statements of the same block.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_FETCH;
            r_fetch_pc    <= RESET_PC;
            r_drain_addr  <= 32'h0000_0000;
            r_req_pending <= 1'b0;
        end else begin
            r_req_pending <= w_hold_req;

            if (flush) begin
                r_fetch_pc <= w_flush_target;
                if (w_hold_req) begin
                    // A request is on the bus and cannot be retracted. When
                    // already draining, w_imem_addr is r_drain_addr itself,
                    // so the held address is unchanged.
                    r_state      <= ST_DRAIN;
                    r_drain_addr <= w_imem_addr;
                end else begin
                    r_state <= ST_FETCH;
                end
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        if (w_resp) begin
                            r_fetch_pc <= r_fetch_pc + 32'd4;
                            if (imem_error) begin
                                r_state <= ST_HALT;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (imem_ready) begin
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_HALT: begin
                        // Only a flush leaves HALT.
                    end
                    default: begin
                        r_state <= ST_FETCH;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the entry array has no reset; an entry is only observable after
    // it has been written, because out_valid is derived from r_count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_pc_q[r_wr_ptr]    <= r_fetch_pc;
            r_instr_q[r_wr_ptr] <= imem_rdata;
            r_fault_q[r_wr_ptr] <= imem_error;
        end
    end

    // ------------------------------------------------------------------
    // Decoder side
    // ------------------------------------------------------------------
    assign w_out_valid = (r_count != '0);

    assign out_valid = w_out_valid;
    assign out_instr = w_out_valid ? r_instr_q[r_rd_ptr] : NOP_INSTR;
    assign out_pc    = w_out_valid ? r_pc_q[r_rd_ptr]    : 32'h0000_0000;
    assign out_fault = w_out_valid ? r_fault_q[r_rd_ptr] : 1'b0;

endmodule

// File: tb/tb_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_buffer
//
// Directed bench for fetch_buffer with DEPTH=4 and RESET_PC=0x100. The
// instruction memory returns (address ^ INSTR_KEY) so every instruction word
// is predictable from its PC; imem_error fires when the address matches
// err_addr. Inputs change 1 time unit after a rising edge and outputs are
// compared right after that, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_fetch_buffer;

    localparam logic [31:0] INSTR_KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_error;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        out_ready;

    logic [31:0] err_addr;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    fetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .imem_valid (imem_valid),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .imem_error (imem_error),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_fault  (out_fault),
        .out_ready  (out_ready)
    );

    // Memory model: data is a fixed function of the address.
    assign imem_rdata = imem_addr ^ INSTR_KEY;
    assign imem_error = (imem_addr == err_addr);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        flush_pc   = 32'h0;
        imem_ready = 1'b1;
        out_ready  = 1'b1;
        err_addr   = 32'h0000_0002;   // unaligned: never matches a fetch

        // ---------------- reset values ----------------
        repeat (2) @(posedge clock);
        #1;
        check_b("rst_imem_valid", imem_valid, 1'b0);
        check_b("rst_out_valid",  out_valid,  1'b0);
        check  ("rst_out_instr",  out_instr,  NOP);
        check  ("rst_out_pc",     out_pc,     32'h0);
        check_b("rst_out_fault",  out_fault,  1'b0);

        reset = 1'b0;
        #1;
        check_b("first_req_valid", imem_valid, 1'b1);
        check  ("first_req_addr",  imem_addr,  32'h0000_0100);
        check_b("first_req_empty", out_valid,  1'b0);

        // ---------------- zero-wait streaming ----------------
        tick();
        check_b("stream0_valid", out_valid, 1'b1);
        check  ("stream0_pc",    out_pc,    32'h0000_0100);
        check  ("stream0_instr", out_instr, 32'h0000_0100 ^ INSTR_KEY);
        check  ("stream0_addr",  imem_addr, 32'h0000_0104);
        tick();
        check  ("stream1_pc",    out_pc,    32'h0000_0104);
        tick();
        check  ("stream2_pc",    out_pc,    32'h0000_0108);
        check  ("stream2_instr", out_instr, 32'h0000_0108 ^ INSTR_KEY);

        // ---------------- backpressure fills the FIFO ----------------
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        check_b("full_no_req",   imem_valid, 1'b0);
        check  ("full_head_pc",  out_pc,     32'h0000_0108);
        tick();
        check_b("full_stall_req", imem_valid, 1'b0);
        check  ("full_stall_pc",  out_pc,     32'h0000_0108);

        out_ready = 1'b1;
        tick();
        check  ("drain0_pc",   out_pc,     32'h0000_010C);
        check_b("resume_req",  imem_valid, 1'b1);
        check  ("resume_addr", imem_addr,  32'h0000_0118);
        tick();
        check  ("drain1_pc",   out_pc,     32'h0000_0110);
        tick();
        check  ("drain2_pc",   out_pc,     32'h0000_0114);
        tick();
        check  ("drain3_pc",   out_pc,     32'h0000_0118);
        check  ("drain3_instr", out_instr, 32'h0000_0118 ^ INSTR_KEY);
        check  ("drain3_addr", imem_addr,  32'h0000_0124);

        // ---------------- flush with response + pop, count 3 ----------------
        flush    = 1'b1;
        flush_pc = 32'h0000_0200;
        tick();
        flush      = 1'b0;
        imem_ready = 1'b0;
        check_b("fl_same_empty", out_valid, 1'b0);
        check  ("fl_same_pc",    out_pc,    32'h0);
        check  ("fl_same_instr", out_instr, NOP);
        check_b("fl_same_req",   imem_valid, 1'b1);
        check  ("fl_same_addr",  imem_addr, 32'h0000_0200);

        // ---------------- flush while a request is outstanding ----------------
        tick();
        check_b("wait_req",  imem_valid, 1'b1);
        check  ("wait_addr", imem_addr,  32'h0000_0200);
        flush    = 1'b1;
        flush_pc = 32'h0000_0800;
        tick();
        flush = 1'b0;
        check_b("drain_req",  imem_valid, 1'b1);
        check  ("drain_addr", imem_addr,  32'h0000_0200);
        flush    = 1'b1;
        flush_pc = 32'h0000_1003;
        tick();
        flush = 1'b0;
        check  ("drain2_addr",  imem_addr, 32'h0000_0200);
        check_b("drain2_empty", out_valid, 1'b0);
        imem_ready = 1'b1;
        tick();
        check_b("drain_drop",    out_valid,  1'b0);
        check_b("redir_req",     imem_valid, 1'b1);
        check  ("redir_addr",    imem_addr,  32'h0000_1000);
        tick();
        check_b("redir_valid",   out_valid,  1'b1);
        check  ("redir_pc",      out_pc,     32'h0000_1000);
        check  ("redir_instr",   out_instr,  32'h0000_1000 ^ INSTR_KEY);

        // ---------------- fetch fault ----------------
        flush    = 1'b1;
        flush_pc = 32'h0000_0100;
        err_addr = 32'h0000_010C;
        tick();
        flush = 1'b0;
        check  ("err_start_addr", imem_addr, 32'h0000_0100);
        check_b("err_start_empty", out_valid, 1'b0);
        tick();
        tick();
        tick();
        check  ("pre_err_pc",    out_pc,    32'h0000_0108);
        check_b("pre_err_fault", out_fault, 1'b0);
        tick();
        check_b("err_valid",   out_valid,  1'b1);
        check  ("err_pc",      out_pc,     32'h0000_010C);
        check_b("err_fault",   out_fault,  1'b1);
        check  ("err_instr",   out_instr,  32'h0000_010C ^ INSTR_KEY);
        check_b("halt_no_req", imem_valid, 1'b0);
        tick();
        check_b("halt_empty",  out_valid,  1'b0);
        check_b("halt_fault0", out_fault,  1'b0);
        tick();
        tick();
        check_b("halt_still",  imem_valid, 1'b0);

        err_addr = 32'h0000_0002;
        flush    = 1'b1;
        flush_pc = 32'h0000_0040;
        tick();
        flush = 1'b0;
        check_b("unhalt_req",  imem_valid, 1'b1);
        check  ("unhalt_addr", imem_addr,  32'h0000_0040);
        tick();
        check  ("unhalt_pc",    out_pc,    32'h0000_0040);
        check_b("unhalt_fault", out_fault, 1'b0);

        // ---------------- address wrap ----------------
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        check  ("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        check  ("wrap_pc0",   out_pc,    32'hFFFF_FFFC);
        check  ("wrap_addr1", imem_addr, 32'h0000_0000);
        tick();
        check_b("wrap_valid", out_valid, 1'b1);
        check  ("wrap_pc1",   out_pc,    32'h0000_0000);

        // ---------------- reset mid-transaction ----------------
        out_ready  = 1'b0;
        imem_ready = 1'b0;
        tick();
        check_b("mid_req",  imem_valid, 1'b1);
        check  ("mid_addr", imem_addr,  32'h0000_0004);
        reset = 1'b1;
        #1;
        check_b("mid_rst_req",   imem_valid, 1'b0);
        check_b("mid_rst_valid", out_valid,  1'b0);
        check  ("mid_rst_pc",    out_pc,     32'h0);
        check  ("mid_rst_instr", out_instr,  NOP);
        tick();
        reset      = 1'b0;
        imem_ready = 1'b1;
        #1;
        check_b("post_rst_req",  imem_valid, 1'b1);
        check  ("post_rst_addr", imem_addr,  32'h0000_0100);
        tick();
        check  ("post_rst_pc",   out_pc,     32'h0000_0100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Generates sequential PCs and fetches 32-bit words over the single-outstanding instruction memory handshake.
- Queues {pc, instr, fault} in a small FIFO and presents the head entry to the decoder with a valid/ready handshake.
- On redirect from execute (branch, jump, trap, mret) it discards queued and in-flight fetches and restarts at the new PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  redirect request from execute.
- flush_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- imem_valid  out  1  fetch request active.
- imem_addr  out  32  fetch address; stable while imem_valid is high.
- imem_ready  in  1  response valid this cycle; completes the request.
- imem_rdata  in  32  instruction word; sampled when imem_ready is high.
- imem_error  in  1  access fault; qualified by imem_ready.
- out_valid  out  1  head entry valid toward the decoder.
- out_instr  out  32  head instruction; 32'h00000013 (nop) when out_valid is 0.
- out_pc  out  32  head PC; 0 when out_valid is 0.
- out_fault  out  1  head entry carries a fetch fault.
- out_ready  in  1  decoder accepts the head entry.

Behaviour:
- State:
  - fetch_pc: 32 bit.
  - state ∈ {FETCH, DRAIN, HALT}.
  - FIFO: DEPTH entries, rd/wr pointers, count of 0..DEPTH.
- Reset, while asserted:
  - fetch_pc = RESET_PC, state = FETCH, FIFO empty.
  - Outputs: imem_valid = 0, out_valid = 0, out_instr = nop, out_pc = 0, out_fault = 0.
- Request rule:
  - imem_valid = (state==FETCH && count<DEPTH) || state==DRAIN.
  - imem_addr = fetch_pc.
  - Once imem_valid rises, imem_valid and imem_addr hold until an imem_ready cycle. A request is never retracted. The count<DEPTH check applies only at request start.
  - At most one request is outstanding.
- Response in FETCH (imem_ready=1, flush=0):
  - Push {fetch_pc, imem_rdata, imem_error}.
  - fetch_pc += 4, wrapping mod 2^32.
  - If imem_error: state → HALT and no further requests. The faulting entry still flows to the decoder.
- Output side:
  - out_valid = (count != 0).
  - out_* driven from the head entry, combinationally from registers.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
- Latency and throughput:
  - A response at edge N makes out_valid high after edge N.
  - With a zero-wait memory (imem_ready tied high), throughput is 1 instruction/cycle while the decoder accepts.
  - When count==DEPTH, the request is not started that cycle even if a pop occurs.
- Flush (highest priority):
  - FIFO is cleared at the edge; push and pop that cycle are ignored. out_valid = 0 next cycle.
  - fetch_pc ← {flush_pc[31:2], 2'b00}.
  - If a request is outstanding and imem_ready=0 that cycle: state → DRAIN. Otherwise state → FETCH (this includes leaving HALT).
  - A response arriving in the flush cycle is discarded.
- DRAIN:
  - imem_valid is held with the old address; fetch_pc already holds the new target, and a separate drain_addr register keeps imem_addr stable.
  - On imem_ready: discard data and error, state → FETCH. The new fetch starts the next cycle.
  - A flush arriving during DRAIN updates fetch_pc only and state stays DRAIN.
- HALT:
  - imem_valid = 0. The FIFO continues draining to the decoder.
  - Exits only on flush.
- Reset asserted mid-transaction: all state is cleared immediately. The memory side must tolerate request abandonment on reset.

Test Plan:
- Reset with RESET_PC=0x100, imem_ready tied high, out_ready high → out_pc sequence 0x100, 0x104, 0x108… on consecutive cycles; first out_valid one cycle after the first request.
- out_ready held 0, DEPTH=4 → exactly 4 responses accepted, then imem_valid=0. Release out_ready → entries emerge in order and fetching resumes with no PC gap.
- Request to 0x200 outstanding with imem_ready low, then flush with flush_pc=0x1003 → imem_addr stays 0x200 until imem_ready; that data is dropped; the next request is to 0x1000; out_pc first shows 0x1000.
- imem_error=1 on the fetch of 0x10C → entry shows out_fault=1, out_pc=0x10C; no further imem_valid. A later flush to 0x40 resumes fetching at 0x40 with out_fault=0.
- Flush in the same cycle as imem_ready and a pop with FIFO count 3 → FIFO empty next cycle, response not enqueued, next imem_addr equals flush_pc.
- fetch_pc=0xFFFFFFFC response → next imem_addr 0x00000000.
